// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU
// load/store port (requester 0) and a loader/debug master (requester 1).
module dmem_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             we0,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [2:0]       funct3_0,
  output logic             ack0,
  output logic [WIDTH-1:0] rdata0,
  input  logic             req1,
  input  logic             we1,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wdata1,
  input  logic [2:0]       funct3_1,
  output logic             ack1,
  output logic [WIDTH-1:0] rdata1,
  output logic             mem_write,
  output logic [WIDTH-1:0] mem_wr_addr,
  output logic [WIDTH-1:0] mem_wr_data,
  output logic [2:0]       mem_funct3,
  input  logic [WIDTH-1:0] mem_read_data,
  output logic             busy,
  output logic             gnt
);

  // Handshake: reqN is held high until ackN; ackN is a single-cycle pulse
  // one cycle after the memory access, with rdataN valid while ackN is high.
  typedef enum logic {IDLE, ACCESS} state_t;

  state_t           state, state_nxt;
  logic             last_ptr;
  logic             start;
  logic             win;
  logic             l_we;
  logic [WIDTH-1:0] l_addr;
  logic [WIDTH-1:0] l_wdata;
  logic [2:0]       l_funct3;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    win       = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          start     = 1'b1;
          state_nxt = ACCESS;
          // On a tie the requester that was not served last wins.
          if (req0 && req1) win = ~last_ptr;
          else              win = req1;
        end
      end
      ACCESS: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last_ptr <= 1'b1;
      gnt      <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rdata0   <= '0;
      rdata1   <= '0;
      l_we     <= 1'b0;
      l_addr   <= '0;
      l_wdata  <= '0;
      l_funct3 <= '0;
    end else begin
      state <= state_nxt;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      if (start) begin
        gnt      <= win;
        l_we     <= win ? we1      : we0;
        l_addr   <= win ? addr1    : addr0;
        l_wdata  <= win ? wdata1   : wdata0;
        l_funct3 <= win ? funct3_1 : funct3_0;
      end
      if (state == ACCESS) begin
        last_ptr <= gnt;
        if (gnt) begin
          ack1 <= 1'b1;
          if (!l_we) rdata1 <= mem_read_data;
        end else begin
          ack0 <= 1'b1;
          if (!l_we) rdata0 <= mem_read_data;
        end
      end
    end
  end

  // Memory bus is driven only during ACCESS, so an async reset drops it at once.
  assign busy        = (state == ACCESS);
  assign mem_write   = busy & l_we;
  assign mem_wr_addr = busy ? l_addr   : '0;
  assign mem_wr_data = busy ? l_wdata  : '0;
  assign mem_funct3  = busy ? l_funct3 : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level model of memory contents,
// round-robin pointer and per-requester read data.
module tb_dmem_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0, we0, req1, we1;
  logic [W-1:0] addr0, wdata0, addr1, wdata1;
  logic [2:0]   funct3_0, funct3_1;
  logic         ack0, ack1, mem_write, busy, gnt;
  logic [W-1:0] rdata0, rdata1, mem_wr_addr, mem_wr_data, mem_read_data;
  logic [2:0]   mem_funct3;

  logic [W-1:0] dmem    [0:63];
  logic [W-1:0] exp_mem [0:63];
  logic [W-1:0] exp_rdata [2];
  int           ptr;
  int           n_tests = 0;
  int           n_fail  = 0;

  dmem_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .funct3_0(funct3_0),
    .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .funct3_1(funct3_1),
    .ack1(ack1), .rdata1(rdata1),
    .mem_write(mem_write), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_funct3(mem_funct3), .mem_read_data(mem_read_data),
    .busy(busy), .gnt(gnt)
  );

  // Clock and the data memory the arbiter drives (word-indexed, 64 words).
  always #5 clk = ~clk;
  assign mem_read_data = dmem[mem_wr_addr[7:2]];
  always @(posedge clk) if (mem_write) dmem[mem_wr_addr[7:2]] <= mem_wr_data;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int r, input logic rq, input logic we, input logic [W-1:0] a,
                       input logic [W-1:0] d, input logic [2:0] f);
    if (r == 0) begin
      req0 = rq; we0 = we; addr0 = a; wdata0 = d; funct3_0 = f;
    end else begin
      req1 = rq; we1 = we; addr1 = a; wdata1 = d; funct3_1 = f;
    end
  endtask

  // Round-robin rule: a lone requester wins; on a tie the one not served last wins.
  function automatic int pick(input bit r0, input bit r1);
    if (r0 && r1) return 1 - ptr;
    return r1 ? 1 : 0;
  endfunction

  // Called at a negedge with requester w's request already applied and DUT idle.
  task automatic expect_access(input int w, input string tag);
    logic         cw;
    logic [W-1:0] ca, cd;
    logic [2:0]   cf;
    int           idx;
    cw = (w == 1) ? we1 : we0;
    ca = (w == 1) ? addr1 : addr0;
    cd = (w == 1) ? wdata1 : wdata0;
    cf = (w == 1) ? funct3_1 : funct3_0;
    @(negedge clk);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_gnt"}, 32'(gnt), 32'(w));
    check({tag, "_mwe"}, 32'(mem_write), 32'(cw));
    check({tag, "_maddr"}, mem_wr_addr, ca);
    check({tag, "_mdata"}, mem_wr_data, cd);
    check({tag, "_mf3"}, 32'(mem_funct3), 32'(cf));
    // Disturb the winner's inputs mid-access; the in-flight access must not change.
    drive(w, 1'b0, ~cw, ca + 32'd4, ~cd, ~cf);
    @(negedge clk);
    idx = int'(ca[7:2]);
    if (cw) exp_mem[idx] = cd;
    else    exp_rdata[w] = exp_mem[idx];
    ptr = w;
    check({tag, "_ack0"}, 32'(ack0), 32'(w == 0));
    check({tag, "_ack1"}, 32'(ack1), 32'(w == 1));
    check({tag, "_rdata0"}, rdata0, exp_rdata[0]);
    check({tag, "_rdata1"}, rdata1, exp_rdata[1]);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int acks;
    int w;
    int r;
    for (int i = 0; i < 64; i++) begin
      exp_mem[i] = $urandom;
      dmem[i]    = exp_mem[i];
    end
    exp_mem[4] = 32'hDEADBEEF;
    dmem[4]    = 32'hDEADBEEF;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    ptr = 1;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0, 3'd0);
    drive(1, 1'b0, 1'b0, '0, '0, 3'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ack0", 32'(ack0), 32'd0);
    check("rst_ack1", 32'(ack1), 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mwe", 32'(mem_write), 32'd0);

    // Directed load, then store from requester 1 read back by requester 0.
    drive(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
    expect_access(0, "load10");
    check("load10_value", rdata0, 32'hDEADBEEF);
    drive(1, 1'b1, 1'b1, 32'h20, 32'h12345678, 3'b010);
    expect_access(1, "store20");
    drive(0, 1'b1, 1'b0, 32'h20, 32'h0, 3'b010);
    expect_access(0, "load20");
    check("load20_value", rdata0, 32'h12345678);

    // Reset in the middle of a store to 0x30.
    drive(0, 1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 3'b010);
    @(negedge clk);
    check("rstmid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("rstmid_mwe", 32'(mem_write), 32'd0);
    check("rstmid_idle", 32'(busy), 32'd0);
    drive(0, 1'b0, 1'b0, '0, '0, 3'd0);
    @(negedge clk);
    reset = 1'b0;
    ptr = 1;
    exp_rdata[0] = '0;
    exp_rdata[1] = '0;
    @(negedge clk);
    check("rstmid_ack0", 32'(ack0), 32'd0);
    check("rstmid_ack1", 32'(ack1), 32'd0);
    check("rstmid_gnt", 32'(gnt), 32'd0);
    check("rstmid_mem30", dmem[12], exp_mem[12]);

    // Both requesters held for 8 cycles: grants alternate, 4 single-cycle acks.
    drive(0, 1'b1, 1'b0, 32'h50, '0, 3'b010);
    drive(1, 1'b1, 1'b0, 32'h54, '0, 3'b010);
    acks = 0;
    w = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("both_ackpair_%0d", k), 32'(ack0 & ack1), 32'd0);
      if (ack0 | ack1) acks++;
      if (k % 2 == 1) begin
        w = pick(1'b1, 1'b1);
        check($sformatf("both_busy_%0d", k), 32'(busy), 32'd1);
        check($sformatf("both_gnt_%0d", k), 32'(gnt), 32'(w));
      end else begin
        exp_rdata[w] = exp_mem[(w == 0) ? 20 : 21];
        ptr = w;
        check($sformatf("both_ack0_%0d", k), 32'(ack0), 32'(w == 0));
        check($sformatf("both_ack1_%0d", k), 32'(ack1), 32'(w == 1));
        check($sformatf("both_rdata_%0d", k), (w == 0) ? rdata0 : rdata1, exp_rdata[w]);
      end
    end
    check("both_ack_count", 32'(acks), 32'd4);
    drive(0, 1'b0, 1'b0, '0, '0, 3'd0);
    drive(1, 1'b0, 1'b0, '0, '0, 3'd0);
    @(negedge clk);

    // Requester 0 alone, held: one access every two cycles.
    drive(0, 1'b1, 1'b0, 32'h60, '0, 3'b010);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("solo_busy_%0d", k), 32'(busy), 32'(k % 2));
      check($sformatf("solo_ack0_%0d", k), 32'(ack0), 32'(k % 2 == 0));
      check($sformatf("solo_ack1_%0d", k), 32'(ack1), 32'd0);
      if (k % 2 == 0) begin
        exp_rdata[0] = exp_mem[24];
        ptr = 0;
        check($sformatf("solo_rdata_%0d", k), rdata0, exp_rdata[0]);
      end
    end
    drive(0, 1'b0, 1'b0, '0, '0, 3'd0);
    @(negedge clk);

    // Address changed 0x40 -> 0x44 during the access (done inside expect_access).
    drive(0, 1'b1, 1'b0, 32'h40, '0, 3'b010);
    expect_access(0, "addrchg");
    check("addrchg_value", rdata0, exp_mem[16]);

    // Randomized single and contending requests.
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(1, 3);
      if (r[0]) drive(0, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2,
                      $urandom, 3'($urandom_range(0, 7)));
      if (r[1]) drive(1, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 63)) << 2,
                      $urandom, 3'($urandom_range(0, 7)));
      w = pick(r[0], r[1]);
      expect_access(w, $sformatf("rnd%0d_a", n));
      if (r == 3) expect_access(1 - w, $sformatf("rnd%0d_b", n));
    end

    @(negedge clk);
    for (int i = 0; i < 64; i++) check($sformatf("final_mem_%0d", i), dmem[i], exp_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter that shares the single-port data memory between the CPU load/store port (requester 0) and a loader/debug master (requester 1).
- Sits between the requesters and data_mem. It latches the winning request, drives the memory for exactly one access cycle, then returns a registered ack and read data to the winner.
- Uses a round-robin policy so neither requester starves. Requester 0 waits on ack, i.e. stalls its pipeline, until the access completes.

Parameters:
WIDTH, 32, address and data width of all request and memory buses

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req0  input  1  requester 0 access request; held high until ack0
we0  input  1  requester 0 write enable (1=store, 0=load)
addr0  input  WIDTH  requester 0 byte address
wdata0  input  WIDTH  requester 0 store data
funct3_0  input  3  requester 0 access size/sign code (RISC-V funct3)
ack0  output  1  one-cycle completion pulse to requester 0
rdata0  output  WIDTH  load data for requester 0; valid while ack0=1
req1, we1, addr1, wdata1, funct3_1  input  1/1/WIDTH/WIDTH/3  requester 1, same meaning as requester 0
ack1  output  1  completion pulse to requester 1
rdata1  output  WIDTH  load data for requester 1
mem_write  output  1  data memory write enable
mem_wr_addr  output  WIDTH  data memory address
mem_wr_data  output  WIDTH  data memory write data
mem_funct3  output  3  data memory access size code
mem_read_data  input  WIDTH  combinational read data from data memory
busy  output  1  1 while state=ACCESS
gnt  output  1  owner of the current or most recent grant (0/1)

Behaviour:
- Reset (async, immediate):
  - state=IDLE; ack0=ack1=0; rdata0=rdata1=0; gnt=0.
  - last-served pointer=1, so requester 0 wins the first tie.
  - All latched request fields=0.
- States: IDLE, ACCESS.
- IDLE:
  - If req0|req1: choose the winner. A single requester wins outright. If both request, the winner is the one not equal to the last-served pointer.
  - Latch the winner's we/addr/wdata/funct3, set gnt=winner, go to ACCESS.
  - Otherwise remain in IDLE.
- ACCESS (exactly one cycle):
  - mem_write=latched we. mem_wr_addr, mem_wr_data and mem_funct3 come from the latched registers.
  - At the closing edge: the winner's rdata register captures mem_read_data (loads only; stores leave rdata unchanged). The winner's ack is set to 1. last-served pointer=gnt. state=IDLE.
- Outputs outside ACCESS: mem_write=0; mem_wr_addr, mem_wr_data and mem_funct3 driven 0. The memory is never written outside ACCESS.
- Ack timing:
  - ack0/ack1 are registered and high for exactly one cycle, namely the cycle after ACCESS.
  - Latency: request seen in IDLE cycle N, memory access in N+1, ack plus data in N+2.
- Back-to-back:
  - A req still high during the ack cycle is treated as a new request and arbitrated in that same cycle.
  - Maximum throughput is one access per 2 cycles.
  - Requesters must drop req in the ack cycle if no further access is wanted.
- Request changes: requests and fields are sampled only in IDLE. Changes to req or fields during ACCESS have no effect on the in-flight access.
- Data hold: rdataN holds its value until the next load completes for that requester. ack0 and ack1 are never high together.
- Reset mid-ACCESS: mem_write drops immediately, no ack is issued, and the pending access is discarded.

Test Plan:
- After reset, req0=1, we0=0, addr0=0x10, with memory[0x10]=0xDEADBEEF -> mem_wr_addr=0x10 in cycle 1; ack0=1 and rdata0=0xDEADBEEF in cycle 2; ack1 stays 0.
- req1=1, we1=1, addr1=0x20, wdata1=0x12345678, funct3_1=3'b010 -> mem_write=1 for exactly one cycle; ack1 pulses; a following req0 load of 0x20 returns 0x12345678.
- req0 and req1 both held high for 8 cycles -> grants alternate 0,1,0,1 starting with 0 (pointer=1 after reset); 4 acks total, each one cycle, never simultaneous.
- req0 held high continuously with req1=0 -> ack0 pulses every 2nd cycle; busy toggles 1,0,1,0.
- Assert reset during ACCESS of a store to 0x30 -> mem_write falls in the same cycle; no ack; memory[0x30] unchanged; state IDLE and gnt=0 after release.
- Change addr0 from 0x40 to 0x44 during ACCESS -> memory accessed at 0x40 only; the returned data belongs to 0x40.
